rom_fill_responder: RTL and testbench
=====================================

# rom_fill_responder

Line-fill responder for the program-memory cache. Accepts a one-cycle fill request naming a 32-word line (3-bit tag) and reads that line out of the synchronous program ROM. It streams the 32 words into the cache RAM as write strobes with offset and data, and pulses `fill_done` when the line is complete. It sits between the program ROM and the cache RAM, and is the memory-side counterpart of the sequencer's hold/fill logic.

## Interface
Parameters:
- `DATA_WIDTH`, 8: ROM/cache word width.
- `WAIT_STATES`, 0: extra ROM cycles per word. ROM read latency is 1+`WAIT_STATES` cycles; legal range 0..3.

Ports:
- `clk`  in  1  single clock, all state on rising edge.
- `sync_reset`  in  1  synchronous, active-high reset.
- `fill_req`  in  1  request strobe; sampled only while idle.
- `fill_tag`  in  3  line tag, which is PC[7:5] of the line to fill.
- `fill_word`  in  5  critical word offset (used only with `CRITICAL_WORD_FIRST_EN`).
- `rom_address`  out  8  registered ROM address, {latched tag, current offset}.
- `rom_data`  in  `DATA_WIDTH`  ROM read data, valid 1+`WAIT_STATES` cycles after the address is presented.
- `cache_wren`  out  1  registered cache write strobe, one cycle per word.
- `cache_wroffset`  out  5  registered cache write offset.
- `cache_wrdata`  out  `DATA_WIDTH`  equals `rom_data` combinationally.
- `fill_busy`  out  1  high from the cycle after acceptance until `fill_done`.
- `fill_done`  out  1  one-cycle completion pulse.

## Operation
- FSM states:
  - IDLE.
  - ADDR: word address presented and held `WAIT_STATES`+1 cycles.
  - DONE: one cycle, `fill_done`=1, `fill_busy`=0.
- Words are requested pipelined. The address for word k+1 is presented while the write for word k is pending.
- A separate 5-bit address counter and a 5-bit write counter are kept. Both start at the start offset and increment mod 32, wrapping 31 -> 0.
- A 6-bit word-issued count terminates the request phase after 32 addresses. A 6-bit word-written count terminates the fill after 32 writes.
- Acceptance: in IDLE with `fill_req`=1, the following are latched at the next edge: the tag, and the start offset (`fill_word` or 0). The FSM then goes to ADDR.
- `fill_req` in any state other than IDLE is ignored, not queued.
- `fill_req` during the DONE cycle is ignored. The earliest new acceptance is the cycle after DONE.
- `cache_wren` is asserted exactly 32 times per fill, each time for exactly one cycle. The offsets are the start offset, start+1, ... mod 32, each offset exactly once.
- `rom_address`[7:5] stays constant for the whole fill, equal to the latched tag.
- `sync_reset` at any time, including mid-fill: at the next edge the FSM goes to IDLE and every output is 0. No further `cache_wren` occurs. The partial line is abandoned; the cache tag must be treated as invalid by the consumer.
- Reset values: `rom_address`=0, `cache_wren`=0, `cache_wroffset`=0, `fill_busy`=0, `fill_done`=0.

## Timing
Let W = `WAIT_STATES`, and let cycle 0 be the cycle in which `fill_req`=1 is seen in IDLE.
- Cycle 1: `fill_busy`=1, `rom_address`={tag, start}.
- Word k address is presented in cycles 1+k(W+1) through (k+1)(W+1).
- Word k write: `cache_wren`=1 in cycle 2+W+k(W+1), with `cache_wroffset`=(start+k) mod 32.
- Last write is in cycle 33+32W.
- `fill_done`=1 and `fill_busy`=0 in cycle 34+32W.
- For W=0: writes occur in cycles 2..33, done in cycle 34, total 34-cycle fill.
- After the last address has been issued, `rom_address` holds its final value until the next acceptance.

## Configuration
- `CRITICAL_WORD_FIRST_EN` defined: the start offset is `fill_word`. Streaming begins at the requested word and wraps through 31 -> 0 back to `fill_word`-1. This lets the sequencer release hold after the first write.
- Not defined: `fill_word` is ignored and the start offset is always 0. Offsets stream 0..31 in order.

## Test plan
- Reset then a single fill with W=0, `fill_tag`=3'd5: `rom_address` runs 8'hA0..8'hBF from cycle 1; `cache_wren` is high in cycles 2..33 with offsets 0..31 and `cache_wrdata`=ROM[8'hA0+k]; `fill_done` pulses in cycle 34.
- With `CRITICAL_WORD_FIRST_EN` defined, `fill_tag`=2, `fill_word`=30: offsets written are 30, 31, 0, 1, ..., 29; the first write is ROM[8'h5E] at cycle 2; `rom_address` wraps 8'h5F -> 8'h40.
- W=2, `fill_tag`=0: writes occur at cycles 4, 7, ..., 97; `fill_done` is at cycle 98; each address is held 3 cycles.
- `fill_req` pulsed at cycles 5 and 34 (the DONE cycle) of a W=0 fill: both are ignored, and there is no second fill. A request at cycle 35 is accepted, with `fill_busy` high in cycle 36.
- `sync_reset` asserted in cycle 10 of a W=0 fill: from cycle 11 all outputs are 0, and no `cache_wren` occurs after cycle 10. A new request after reset yields a complete 32-word fill.

Source files
------------

// File: rtl/rom_fill_responder.sv
// Line-fill responder: streams one 32-word program-ROM line into the cache RAM.
// Optional macro CRITICAL_WORD_FIRST_EN starts the stream at fill_word instead of offset 0.
module rom_fill_responder #(
    parameter int unsigned DATA_WIDTH  = 8,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic                  clk,
    input  logic                  sync_reset,
    input  logic                  fill_req,
    input  logic [2:0]            fill_tag,
    input  logic [4:0]            fill_word,
    output logic [7:0]            rom_address,
    input  logic [DATA_WIDTH-1:0] rom_data,
    output logic                  cache_wren,
    output logic [4:0]            cache_wroffset,
    output logic [DATA_WIDTH-1:0] cache_wrdata,
    output logic                  fill_busy,
    output logic                  fill_done
);

    localparam logic [1:0] LAST_WAIT  = 2'(WAIT_STATES);
    localparam logic [5:0] LINE_WORDS = 6'd32;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ADDR,
        ST_DONE
    } state_t;

    state_t     r_state, w_state_nxt;
    logic [2:0] r_tag, w_tag_nxt;
    logic [4:0] r_addr_cnt, w_addr_cnt_nxt;
    logic [4:0] r_wr_cnt, w_wr_cnt_nxt;
    logic [5:0] r_issued, w_issued_nxt;
    logic [5:0] r_written, w_written_nxt;
    logic [1:0] r_wait, w_wait_nxt;
    logic [7:0] r_rom_address, w_rom_address_nxt;
    logic       r_wren, w_wren_nxt;
    logic [4:0] r_wroffset, w_wroffset_nxt;
    logic       r_busy, w_busy_nxt;
    logic       r_done, w_done_nxt;

    logic [4:0] w_start;
    logic       w_trigger;
    logic       w_issue;

`ifdef CRITICAL_WORD_FIRST_EN
    assign w_start = fill_word;
`else
    logic w_unused_fill_word;
    assign w_start            = 5'd0;
    assign w_unused_fill_word = ^fill_word;
`endif

    // End of an address hold: its ROM word is valid next cycle, so write it then.
    assign w_trigger = (r_state == ST_ADDR) && (r_wait == LAST_WAIT) && (r_written != LINE_WORDS);
    assign w_issue   = w_trigger && (r_issued != LINE_WORDS);

    always_ff @(posedge clk) begin
        if (sync_reset) r_state <= ST_IDLE;
        else            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (fill_req) w_state_nxt = ST_ADDR;
            ST_ADDR: if (r_written == LINE_WORDS) w_state_nxt = ST_DONE;
            ST_DONE: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        w_tag_nxt         = r_tag;
        w_addr_cnt_nxt    = r_addr_cnt;
        w_wr_cnt_nxt      = r_wr_cnt;
        w_issued_nxt      = r_issued;
        w_written_nxt     = r_written;
        w_wait_nxt        = r_wait;
        w_rom_address_nxt = r_rom_address;
        w_wren_nxt        = 1'b0;
        w_wroffset_nxt    = r_wroffset;
        w_busy_nxt        = r_busy;
        w_done_nxt        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (fill_req) begin
                    w_tag_nxt         = fill_tag;
                    w_addr_cnt_nxt    = w_start;
                    w_wr_cnt_nxt      = w_start;
                    w_issued_nxt      = 6'd1;
                    w_written_nxt     = 6'd0;
                    w_wait_nxt        = 2'd0;
                    w_rom_address_nxt = {fill_tag, w_start};
                    w_busy_nxt        = 1'b1;
                end
            end
            ST_ADDR: begin
                w_wait_nxt = (r_wait == LAST_WAIT) ? 2'd0 : r_wait + 2'd1;
                if (w_trigger) begin
                    w_wren_nxt     = 1'b1;
                    w_wroffset_nxt = r_wr_cnt;
                    w_wr_cnt_nxt   = r_wr_cnt + 5'd1;
                    w_written_nxt  = r_written + 6'd1;
                end
                if (w_issue) begin
                    w_addr_cnt_nxt    = r_addr_cnt + 5'd1;
                    w_rom_address_nxt = {r_tag, r_addr_cnt + 5'd1};
                    w_issued_nxt      = r_issued + 6'd1;
                end
                if (r_written == LINE_WORDS) begin
                    w_busy_nxt = 1'b0;
                    w_done_nxt = 1'b1;
                end
            end
            ST_DONE: w_busy_nxt = 1'b0;
            default: w_busy_nxt = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (sync_reset) begin
            r_tag         <= 3'd0;
            r_addr_cnt    <= 5'd0;
            r_wr_cnt      <= 5'd0;
            r_issued      <= 6'd0;
            r_written     <= 6'd0;
            r_wait        <= 2'd0;
            r_rom_address <= 8'd0;
            r_wren        <= 1'b0;
            r_wroffset    <= 5'd0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
        end else begin
            r_tag         <= w_tag_nxt;
            r_addr_cnt    <= w_addr_cnt_nxt;
            r_wr_cnt      <= w_wr_cnt_nxt;
            r_issued      <= w_issued_nxt;
            r_written     <= w_written_nxt;
            r_wait        <= w_wait_nxt;
            r_rom_address <= w_rom_address_nxt;
            r_wren        <= w_wren_nxt;
            r_wroffset    <= w_wroffset_nxt;
            r_busy        <= w_busy_nxt;
            r_done        <= w_done_nxt;
        end
    end

    assign rom_address    = r_rom_address;
    assign cache_wren     = r_wren;
    assign cache_wroffset = r_wroffset;
    assign cache_wrdata   = rom_data;
    assign fill_busy      = r_busy;
    assign fill_done      = r_done;

endmodule

// File: tb/tb_rom_fill_responder.sv
// Bench for rom_fill_responder: W=0 and W=2 instances, per-cycle expectations from closed-form timing.
module tb_rom_fill_responder;

    logic       clk;
    logic       sync_reset;
    logic       fill_req;
    logic       sel;
    logic [2:0] fill_tag;
    logic [4:0] fill_word;

    logic [7:0] a0, a2, d0, d2, wd0, wd2;
    logic       we0, we2, b0, b2, dn0, dn2;
    logic [4:0] off0, off2;
    logic       req0, req2;

    logic [7:0] rom [256];
    logic [7:0] p1, p2;

    logic [7:0] m_addr, m_wrdata;
    logic       m_wren, m_busy, m_done;
    logic [4:0] m_off;

    int total;
    int bad;

    assign req0 = fill_req && !sel;
    assign req2 = fill_req && sel;

    rom_fill_responder #(.DATA_WIDTH(8), .WAIT_STATES(0)) u_dut0 (
        .clk(clk), .sync_reset(sync_reset), .fill_req(req0), .fill_tag(fill_tag),
        .fill_word(fill_word), .rom_address(a0), .rom_data(d0), .cache_wren(we0),
        .cache_wroffset(off0), .cache_wrdata(wd0), .fill_busy(b0), .fill_done(dn0)
    );

    rom_fill_responder #(.DATA_WIDTH(8), .WAIT_STATES(2)) u_dut2 (
        .clk(clk), .sync_reset(sync_reset), .fill_req(req2), .fill_tag(fill_tag),
        .fill_word(fill_word), .rom_address(a2), .rom_data(d2), .cache_wren(we2),
        .cache_wroffset(off2), .cache_wrdata(wd2), .fill_busy(b2), .fill_done(dn2)
    );

    // Synchronous ROMs with read latency 1 and 3.
    always @(posedge clk) begin
        d0 <= rom[a0];
        p1 <= rom[a2];
        p2 <= p1;
        d2 <= p2;
    end

    assign m_addr   = sel ? a2   : a0;
    assign m_wren   = sel ? we2  : we0;
    assign m_off    = sel ? off2 : off0;
    assign m_wrdata = sel ? wd2  : wd0;
    assign m_busy   = sel ? b2   : b0;
    assign m_done   = sel ? dn2  : dn0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // One fill; cycle 0 is the request cycle. pa/pb: extra req pulses, rst_at: reset cycle, tail: idle cycles checked.
    task automatic run_fill(input bit s, input logic [2:0] tag, input logic [4:0] word,
                            input int pa, input int pb, input int rst_at, input int tail);
        int         w;
        int         last;
        int         stop;
        int         start;
        int         k;
        logic [7:0] eaddr;
        logic [4:0] eoff;
        logic       ewren, ebusy, edone;
        logic [7:0] rom_idx;
        w    = s ? 2 : 0;
        last = 34 + 32 * w;
        stop = (rst_at > 0) ? rst_at + 4 : last + tail;
`ifdef CRITICAL_WORD_FIRST_EN
        start = int'(word);
`else
        start = 0;
`endif
        sel       = s;
        fill_tag  = tag;
        fill_word = word;
        fill_req  = 1'b1;
        @(posedge clk); #1;
        fill_req  = 1'b0;
        fill_tag  = 3'($urandom);
        fill_word = 5'($urandom);
        for (int c = 1; c <= stop; c++) begin
            if (rst_at > 0 && c > rst_at) begin
                eaddr = 8'd0; ewren = 1'b0; ebusy = 1'b0; edone = 1'b0; eoff = 5'd0;
            end else begin
                ebusy = (c < last);
                edone = (c == last);
                ewren = (c >= 2 + w) && (c <= last - 1) && (((c - 2 - w) % (w + 1)) == 0);
                k = (c - 1) / (w + 1);
                if (k > 31) k = 31;
                eaddr = {tag, 5'(start + k)};
                eoff  = (c >= 2 + w) ? 5'(start + (c - 2 - w) / (w + 1)) : 5'd0;
            end
            total++;
            if (m_busy !== ebusy) begin
                bad++; $display("FAIL busy W=%0d c=%0d got=%b exp=%b", w, c, m_busy, ebusy);
            end
            total++;
            if (m_done !== edone) begin
                bad++; $display("FAIL done W=%0d c=%0d got=%b exp=%b", w, c, m_done, edone);
            end
            total++;
            if (m_wren !== ewren) begin
                bad++; $display("FAIL wren W=%0d c=%0d got=%b exp=%b", w, c, m_wren, ewren);
            end
            total++;
            if (m_addr !== eaddr) begin
                bad++; $display("FAIL rom_address W=%0d c=%0d got=%h exp=%h", w, c, m_addr, eaddr);
            end
            if (ewren || (rst_at > 0 && c > rst_at)) begin
                total++;
                if (m_off !== eoff) begin
                    bad++; $display("FAIL wroffset W=%0d c=%0d got=%0d exp=%0d", w, c, m_off, eoff);
                end
            end
            if (ewren) begin
                rom_idx = {tag, eoff};
                total++;
                if (m_wrdata !== rom[rom_idx]) begin
                    bad++; $display("FAIL wrdata W=%0d c=%0d got=%h exp=%h", w, c, m_wrdata, rom[rom_idx]);
                end
            end
            fill_req = (c == pa || c == pb);
            if (c == rst_at) sync_reset = 1'b1;
            @(posedge clk); #1;
        end
        fill_req = 1'b0;
    endtask

    task automatic test_reset();
        sync_reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            #1;
            total++;
            if ({m_addr, m_wren, m_off, m_busy, m_done} !== 16'd0) begin
                bad++;
                $display("FAIL reset_state W=%0d got=%h/%b/%0d/%b/%b exp=0", 2 * s, m_addr, m_wren, m_off, m_busy, m_done);
            end
        end
        sync_reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_basic_fill();
        run_fill(1'b0, 3'd5, 5'($urandom), 0, 0, 0, 3);
    endtask

    task automatic test_critical_word();
        run_fill(1'b0, 3'd2, 5'd30, 0, 0, 0, 2);
    endtask

    task automatic test_wait_states();
        run_fill(1'b1, 3'd0, 5'($urandom), 0, 0, 0, 3);
    endtask

    task automatic test_ignored_req();
        run_fill(1'b0, 3'($urandom), 5'($urandom), 5, 34, 0, 0);
        run_fill(1'b0, 3'($urandom), 5'($urandom), 0, 0, 0, 2);
    endtask

    task automatic test_reset_mid_fill();
        run_fill(1'b0, 3'($urandom), 5'($urandom), 0, 0, 10, 0);
        sync_reset = 1'b0;
        @(posedge clk); #1;
        run_fill(1'b0, 3'($urandom), 5'($urandom), 0, 0, 0, 2);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++) begin
            run_fill(1'($urandom), 3'($urandom), 5'($urandom), 0, 0, 0, int'($urandom_range(0, 2)));
        end
    endtask

    initial begin
        total      = 0;
        bad        = 0;
        sync_reset = 1'b1;
        fill_req   = 1'b0;
        sel        = 1'b0;
        fill_tag   = 3'd0;
        fill_word  = 5'd0;
        for (int i = 0; i < 256; i++) rom[i] = 8'($urandom);
        test_reset();
        test_basic_fill();
        test_critical_word();
        test_wait_states();
        test_ignored_req();
        test_reset_mid_fill();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
